// File: rtl/sort_drain_pkg.sv
// Shared definitions for the sort_drain controller: element width, controller
// states and the direction-dependent first drain position.
package sort_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SORT    = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Index of the first element streamed out for a given direction.
    function automatic int first_pos(input int n, input bit descend);
        return descend ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/sort_drain_if.sv
// Streaming output bundle of sort_drain: valid/ready handshake carrying one
// sorted element, its position and an end-of-burst marker.
interface sort_drain_if #(parameter int N = 8) ();
    import sort_pkg::*;

    localparam int IDX_W = $clog2(N);

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_index, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_index, input m_last, output m_ready);

endinterface

// File: rtl/sort_drain.sv
// Sequencer for an external systolic sorter: loads it, waits out the sort,
// snapshots the sorted vector and streams it out one element per handshake.
module sort_drain
    import sort_pkg::*;
#(
    parameter int N       = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  sorter_load,
    input  logic [N*DATA_W-1:0]   sorted_flat,
    sort_drain_if.master          m,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int FIRST_I = first_pos(N, DESCEND);
    localparam int LAST_I  = first_pos(N, !DESCEND);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_I);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_I);
    localparam logic [CNT_W-1:0] SORT_LEN  = CNT_W'(N);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [IDX_W-1:0]  idx_r, idx_s, idx_adv_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic [DATA_W-1:0] shadow_r [N];
    logic              load_r, load_s;
    logic              valid_r, valid_s;
    logic              last_r, last_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              capture_s;
    logic              hs_s;

    // Next-state and next-output decode; abort overrides everything outside IDLE.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        data_s    = data_r;
        last_s    = last_r;
        done_s    = 1'b0;
        capture_s = 1'b0;
        hs_s      = valid_r && m.m_ready;
        idx_adv_s = DESCEND ? (idx_r - IDX_W'(1)) : (idx_r + IDX_W'(1));

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = SORT;
                cnt_s   = '0;
            end
            SORT: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_s == SORT_LEN) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = SORT;
                end
            end
            CAPTURE: begin
                capture_s = 1'b1;
                state_s   = DRAIN;
                idx_s     = FIRST_IDX;
                data_s    = sorted_flat[FIRST_I*DATA_W +: DATA_W];
                last_s    = (FIRST_IDX == LAST_IDX);
            end
            DRAIN: begin
                if (hs_s && (idx_r == LAST_IDX)) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                    idx_s   = '0;
                    data_s  = '0;
                    last_s  = 1'b0;
                end else if (hs_s) begin
                    idx_s  = idx_adv_s;
                    data_s = shadow_r[idx_adv_s];
                    last_s = (idx_adv_s == LAST_IDX);
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                idx_s   = '0;
                data_s  = '0;
                last_s  = 1'b0;
            end
        endcase

        if (abort && (state_r != IDLE)) begin
            state_s   = IDLE;
            cnt_s     = '0;
            idx_s     = '0;
            data_s    = '0;
            last_s    = 1'b0;
            done_s    = 1'b0;
            capture_s = 1'b0;
        end else begin
            capture_s = capture_s;
        end

        valid_s = (state_s == DRAIN);
        busy_s  = (state_s != IDLE);
        load_s  = (state_s == LOAD);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            data_r  <= '0;
            load_r  <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            data_r  <= data_s;
            load_r  <= load_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Snapshot of the sorter output, taken as CAPTURE ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) shadow_r[i] <= '0;
        end else if (capture_s) begin
            for (int i = 0; i < N; i++) shadow_r[i] <= sorted_flat[i*DATA_W +: DATA_W];
        end else begin
            for (int i = 0; i < N; i++) shadow_r[i] <= shadow_r[i];
        end
    end

    assign sorter_load = load_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign m.m_valid   = valid_r;
    assign m.m_data    = data_r;
    assign m.m_index   = idx_r;
    assign m.m_last    = last_r;

endmodule
